// File: rtl/apb_master_bridge.sv
// APB master and four-slot address decoder: turns single-cycle CPU requests into
// APB SETUP/ACCESS transfers, returning slave PRDATA or an error on unmapped/timeout.
module apb_master_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        transfer,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic        PENABLE,
  output logic [3:0]  PSEL,
  input  logic [31:0] PRDATA0,
  input  logic [31:0] PRDATA1,
  input  logic [31:0] PRDATA2,
  input  logic [31:0] PRDATA3,
  input  logic        PREADY0,
  input  logic        PREADY1,
  input  logic        PREADY2,
  input  logic        PREADY3
);

  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e          state_q, state_d;
  logic [31:0]     paddr_q, pwdata_q, rdata_q;
  logic            pwrite_q, mapped_q, ready_q, err_q;
  logic [1:0]      slot_q;
  logic [CntW-1:0] cnt_q;

  logic        req_mapped;
  logic        sel_pready;
  logic [31:0] sel_prdata;
  logic        xfer_ok;
  logic        done;

  // Slots 0..3 occupy 4 KB each at the bottom of the 64 KB window.
  assign req_mapped = (addr[31:16] == BASE_ADDR[31:16]) && (addr[15:14] == 2'b00);

  always_comb begin
    sel_pready = 1'b0;
    sel_prdata = '0;
    case (slot_q)
      2'd0:    begin sel_pready = PREADY0; sel_prdata = PRDATA0; end
      2'd1:    begin sel_pready = PREADY1; sel_prdata = PRDATA1; end
      2'd2:    begin sel_pready = PREADY2; sel_prdata = PRDATA2; end
      default: begin sel_pready = PREADY3; sel_prdata = PRDATA3; end
    endcase
  end

  assign xfer_ok = mapped_q && sel_pready;
  assign done    = (state_q == StAccess) && (!mapped_q || sel_pready || (cnt_q == CntLast));

  // FSM state register
  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (transfer) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (done) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    PSEL    = '0;
    PENABLE = (state_q == StAccess);
    if ((state_q != StIdle) && mapped_q) begin
      PSEL[slot_q] = 1'b1;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      mapped_q <= 1'b0;
      slot_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if ((state_q == StIdle) && transfer) begin
        paddr_q  <= addr;
        pwdata_q <= wdata;
        pwrite_q <= write;
        mapped_q <= req_mapped;
        slot_q   <= addr[13:12];
      end
      cnt_q   <= ((state_q == StAccess) && !done) ? cnt_q + CntW'(1) : '0;
      ready_q <= done;
      err_q   <= done && !xfer_ok;
      rdata_q <= (done && xfer_ok && !pwrite_q) ? sel_prdata : '0;
    end
  end

  assign PADDR  = paddr_q;
  assign PWDATA = pwdata_q;
  assign PWRITE = pwrite_q;
  assign rdata  = rdata_q;
  assign ready  = ready_q;
  assign err    = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge with a registered-PREADY FND slave in slot 1,
// zero-wait slaves in slots 0 and 2, and a never-ready slave in slot 3.
module tb_apb_master_bridge;

  logic        PCLK;
  logic        PRESET;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic        PENABLE;
  logic [3:0]  PSEL;
  logic [31:0] prdata0, prdata1, prdata2, prdata3;
  logic        pready0, pready1, pready2, pready3;

  int checks = 0;
  int errors = 0;

  logic [31:0] fnd_regs [4];

  apb_master_bridge #(
    .BASE_ADDR(32'h1000_0000),
    .TIMEOUT  (16)
  ) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .transfer(transfer),
    .write   (write),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .ready   (ready),
    .err     (err),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA0 (prdata0),
    .PRDATA1 (prdata1),
    .PRDATA2 (prdata2),
    .PRDATA3 (prdata3),
    .PREADY0 (pready0),
    .PREADY1 (pready1),
    .PREADY2 (pready2),
    .PREADY3 (pready3)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Zero-wait slaves and a slave that never responds.
  assign prdata0 = 32'h0000_A5A5;
  assign pready0 = PSEL[0] && PENABLE;
  assign prdata2 = 32'hDEAD_BEEF;
  assign pready2 = PSEL[2] && PENABLE;
  assign prdata3 = 32'h3333_3333;
  assign pready3 = 1'b0;

  // FND-style slave: PREADY registered one edge after PSEL&&PENABLE.
  assign prdata1 = fnd_regs[PADDR[3:2]];
  always @(posedge PCLK) begin
    if (!PRESET) begin
      pready1 <= 1'b0;
      for (int i = 0; i < 4; i++) fnd_regs[i] <= 32'h0;
    end else begin
      pready1 <= PSEL[1] && PENABLE && !pready1;
      if (PSEL[1] && PENABLE && pready1 && PWRITE) fnd_regs[PADDR[3:2]] <= PWDATA;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    transfer = 1'b1;
    write    = w;
    addr     = a;
    wdata    = d;
    @(posedge PCLK);
    #1;
    transfer = 1'b0;
  endtask

  // Counts edges since the accepting edge until ready is seen (-1 if never).
  task automatic wait_ready(input int start, output int edges, output logic [31:0] rd,
                            output logic e, output logic [3:0] seen);
    logic got;
    got   = 1'b0;
    edges = start;
    seen  = 4'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      seen |= PSEL;
      @(posedge PCLK);
      #1;
      edges++;
      if (ready === 1'b1) got = 1'b1;
    end
    if (!got) edges = -1;
    rd = rdata;
    e  = err;
  endtask

  task automatic test_reset();
    PRESET   = 1'b0;
    transfer = 1'b1;
    write    = 1'b1;
    addr     = 32'h1000_1004;
    wdata    = 32'h1;
    for (int i = 0; i < 3; i++) begin
      @(posedge PCLK);
      #1;
      checks++;
      if (PSEL !== 4'b0 || PENABLE !== 1'b0) begin
        errors++;
        $display("FAIL reset_bus edge%0d: PSEL=%b PENABLE=%b, want 0000/0", i, PSEL, PENABLE);
      end
    end
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: ready=%b rdata=%h err=%b, want 0/0/0", ready, rdata, err);
    end
    checks++;
    if (PADDR !== 32'h0 || PWDATA !== 32'h0 || PWRITE !== 1'b0) begin
      errors++;
      $display("FAIL reset_latch: PADDR=%h PWDATA=%h PWRITE=%b, want 0", PADDR, PWDATA, PWRITE);
    end
    PRESET   = 1'b1;
    transfer = 1'b0;
    @(posedge PCLK);
    #1;
    checks++;
    if (PSEL !== 4'b0) begin
      errors++;
      $display("FAIL reset_release: PSEL=%b, want 0000", PSEL);
    end
  endtask

  task automatic test_fnd_write();
    int          n;
    logic [31:0] rd;
    logic        e;
    logic [3:0]  seen;
    issue(1'b1, 32'h1000_1004, 32'd1234);
    checks++;
    if (PSEL !== 4'b0010 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL fnd_setup: PSEL=%b PENABLE=%b, want 0010/0", PSEL, PENABLE);
    end
    checks++;
    if (PADDR !== 32'h1000_1004 || PWDATA !== 32'd1234 || PWRITE !== 1'b1) begin
      errors++;
      $display("FAIL fnd_latch: PADDR=%h PWDATA=%0d PWRITE=%b, want 10001004/1234/1",
               PADDR, PWDATA, PWRITE);
    end
    @(posedge PCLK);
    #1;
    checks++;
    if (PSEL !== 4'b0010 || PENABLE !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL fnd_access: PSEL=%b PENABLE=%b ready=%b, want 0010/1/0",
               PSEL, PENABLE, ready);
    end
    wait_ready(1, n, rd, e, seen);
    checks++;
    if (n !== 3 || e !== 1'b0) begin
      errors++;
      $display("FAIL fnd_write_done: edges=%0d err=%b, want 3/0", n, e);
    end
    @(posedge PCLK);
    #1;
    checks++;
    if (ready !== 1'b0 || PSEL !== 4'b0 || PENABLE !== 1'b0) begin
      errors++;
      $display("FAIL fnd_pulse: ready=%b PSEL=%b PENABLE=%b, want 0/0000/0",
               ready, PSEL, PENABLE);
    end
    checks++;
    if (fnd_regs[1] !== 32'd1234) begin
      errors++;
      $display("FAIL fnd_reg1: got %0d want 1234", fnd_regs[1]);
    end
  endtask

  task automatic test_read();
    int          n;
    logic [31:0] rd;
    logic        e;
    logic [3:0]  seen;
    issue(1'b0, 32'h1000_2008, 32'h0);
    wait_ready(0, n, rd, e, seen);
    checks++;
    if (n !== 2 || rd !== 32'hDEAD_BEEF || e !== 1'b0 || seen !== 4'b0100) begin
      errors++;
      $display("FAIL read_slot2: edges=%0d rdata=%h err=%b psel=%b, want 2/deadbeef/0/0100",
               n, rd, e, seen);
    end
    @(posedge PCLK);
    #1;
    checks++;
    if (ready !== 1'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_pulse: ready=%b rdata=%h, want 0/0", ready, rdata);
    end
  endtask

  task automatic test_write_rdata_zero();
    int          n;
    logic [31:0] rd;
    logic        e;
    logic [3:0]  seen;
    issue(1'b1, 32'h1000_2000, 32'h77);
    wait_ready(0, n, rd, e, seen);
    checks++;
    if (n !== 2 || rd !== 32'h0 || e !== 1'b0) begin
      errors++;
      $display("FAIL write_slot2: edges=%0d rdata=%h err=%b, want 2/0/0", n, rd, e);
    end
    @(posedge PCLK);
    #1;
  endtask

  task automatic test_unmapped();
    int          n;
    logic [31:0] rd;
    logic        e;
    logic [3:0]  seen;
    logic [31:0] bad [2];
    bad[0] = 32'h2000_0000;
    bad[1] = 32'h1000_5000;
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, bad[i], 32'h0);
      wait_ready(0, n, rd, e, seen);
      checks++;
      if (n !== 2 || rd !== 32'h0 || e !== 1'b1 || seen !== 4'b0) begin
        errors++;
        $display("FAIL unmapped_%h: edges=%0d rdata=%h err=%b psel=%b, want 2/0/1/0000",
                 bad[i], n, rd, e, seen);
      end
      @(posedge PCLK);
      #1;
      checks++;
      if (ready !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL unmapped_pulse: ready=%b err=%b, want 0/0", ready, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int          n;
    logic [31:0] rd;
    logic        e;
    logic [3:0]  seen;
    issue(1'b0, 32'h1000_1004, 32'h0);
    wait_ready(0, n, rd, e, seen);
    checks++;
    if (n !== 3 || rd !== 32'd1234 || e !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fnd_read: edges=%0d rdata=%h err=%b, want 3/000004d2/0", n, rd, e);
    end
    // Next request is presented during the ready cycle.
    issue(1'b0, 32'h1000_2008, 32'h0);
    wait_ready(0, n, rd, e, seen);
    checks++;
    if (n !== 2 || rd !== 32'hDEAD_BEEF || e !== 1'b0 || seen !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_slot2: edges=%0d rdata=%h err=%b psel=%b, want 2/deadbeef/0/0100",
               n, rd, e, seen);
    end
    issue(1'b0, 32'h1000_0010, 32'h0);
    wait_ready(0, n, rd, e, seen);
    checks++;
    if (n !== 2 || rd !== 32'h0000_A5A5 || e !== 1'b0 || seen !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_slot0: edges=%0d rdata=%h err=%b psel=%b, want 2/0000a5a5/0/0001",
               n, rd, e, seen);
    end
    @(posedge PCLK);
    #1;
    checks++;
    if (PADDR !== 32'h1000_0010 || PWRITE !== 1'b0) begin
      errors++;
      $display("FAIL hold_paddr: PADDR=%h PWRITE=%b, want 10000010/0", PADDR, PWRITE);
    end
  endtask

  task automatic test_timeout();
    int          n;
    int          extra;
    logic [31:0] rd;
    logic        e;
    logic [3:0]  seen;
    issue(1'b0, 32'h1000_3000, 32'h0);
    @(posedge PCLK);
    #1;
    @(posedge PCLK);
    #1;
    transfer = 1'b1;
    addr     = 32'h1000_2008;
    @(posedge PCLK);
    #1;
    transfer = 1'b0;
    wait_ready(3, n, rd, e, seen);
    checks++;
    if (n !== 17 || rd !== 32'h0 || e !== 1'b1) begin
      errors++;
      $display("FAIL timeout: edges=%0d rdata=%h err=%b, want 17/0/1", n, rd, e);
    end
    checks++;
    if (PADDR !== 32'h1000_3000) begin
      errors++;
      $display("FAIL timeout_paddr: PADDR=%h want 10003000", PADDR);
    end
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge PCLK);
      #1;
      if (ready !== 1'b0 || PSEL !== 4'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL timeout_no_second: busy_cycles=%0d want 0", extra);
    end
  endtask

  task automatic test_reset_mid_access();
    int          n;
    int          pulses;
    logic [31:0] rd;
    logic        e;
    logic [3:0]  seen;
    issue(1'b0, 32'h1000_3000, 32'h0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    checks++;
    if (PSEL !== 4'b0 || PENABLE !== 1'b0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_bus: PSEL=%b PENABLE=%b ready=%b, want 0000/0/0",
               PSEL, PENABLE, ready);
    end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge PCLK);
      #1;
      if (ready !== 1'b0 || PSEL !== 4'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet: busy_cycles=%0d want 0", pulses);
    end
    issue(1'b0, 32'h1000_2008, 32'h0);
    wait_ready(0, n, rd, e, seen);
    checks++;
    if (n !== 2 || rd !== 32'hDEAD_BEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_next: edges=%0d rdata=%h err=%b, want 2/deadbeef/0", n, rd, e);
    end
    @(posedge PCLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_fnd_write();
    test_read();
    test_write_rdata_zero();
    test_unmapped();
    test_back_to_back();
    test_timeout();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
# apb_master_bridge

CPU-side APB master and address decoder for the RISC-V APB peripheral subsystem. It converts single-cycle CPU load/store requests into APB SETUP/ACCESS transfers and selects one of four slave slots, including the FND controller peripheral. It returns the selected slave's PRDATA, or an error on unmapped addresses and timeouts. It sits directly upstream of every APB peripheral and drives their PSEL/PENABLE/PADDR/PWDATA/PWRITE.

## Interface
Parameters:
- BASE_ADDR, 32'h1000_0000, peripheral window base; only bits [31:16] are compared.
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before abort (≥2).

Ports (one clock; reset is synchronous and active-low):
- PCLK  in  1  system clock; all state changes on its rising edge.
- PRESET  in  1  synchronous active-low reset; takes effect only on a rising PCLK edge while PRESET==0.
- transfer  in  1  CPU request strobe; sampled only in IDLE.
- write  in  1  1=write, 0=read; captured with transfer.
- addr  in  32  byte address; captured with transfer.
- wdata  in  32  write data; captured with transfer.
- rdata  out  32  read data; valid while ready==1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  valid with ready; 1 = unmapped address or timeout.
- PADDR  out  32  latched addr.
- PWDATA  out  32  latched wdata.
- PWRITE  out  1  latched write.
- PENABLE  out  1  APB enable.
- PSEL  out  4  one-hot slave select; bit n corresponds to slot n.
- PRDATA0..PRDATA3  in  32 each  slave read data.
- PREADY0..PREADY3  in  1 each  slave ready.

## Operation
- Decode: mapped when addr[31:16]==BASE_ADDR[31:16] and addr[15:12]<4. Slot = addr[15:12], which gives a 4 KB stride per slot. Any other address is unmapped.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE: if transfer==1, latch addr, wdata, write and the decoded slot into registers, then go to SETUP. Otherwise stay in IDLE.
- SETUP: PSEL[slot]=1 (all PSEL bits 0 if unmapped) and PENABLE=0. Go to ACCESS unconditionally.
- ACCESS: PSEL held and PENABLE=1. The timeout counter increments every ACCESS cycle.
  - Unmapped: complete at the first ACCESS edge with err=1 and rdata=0.
  - PREADY of the selected slot ==1: complete. rdata = PRDATA of that slot if the latched write==0, else 0. err=0.
  - Counter reaches TIMEOUT−1 without PREADY: complete with err=1 and rdata=0.
  - Otherwise stay in ACCESS.
- On completion: go to IDLE, pulse ready high for exactly the following cycle, clear the counter, and drop PSEL/PENABLE.
- PREADY/PRDATA are sampled only in ACCESS and only from the selected slot. Unselected slots are ignored.
- transfer asserted outside IDLE is ignored and dropped. The CPU issues the next request no earlier than the cycle ready is high.
- PADDR, PWDATA and PWRITE hold their latched values from SETUP until the next request is accepted. They are not cleared on completion.

## Timing
- Reset values: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, err=0, counter=0.
- Reset mid-transfer: the bus is idle after that edge. No ready pulse is produced. The latched request is discarded.
- Transfer sampled at edge E0:
  - SETUP after E0.
  - ACCESS after E0+1.
  - A zero-wait slave (combinational PREADY) completes at E0+2, so ready is high in the cycle after E0+2.
- FND controller peripheral: it registers PREADY one edge after it sees PSEL&&PENABLE. Completion is at E0+3, so ready is high after E0+3 (3-edge latency).
- Back-to-back: the earliest new transfer is sampled at the edge that ends the ready cycle. Because the FSM returns through IDLE, the previous slave's lingering PREADY is never seen in the new ACCESS.
- Timeout: ACCESS lasts exactly TIMEOUT cycles. ready follows at edge E0+1+TIMEOUT.
- ready and err are registered, never high for more than one cycle, and are 0 whenever state≠IDLE.

## Test plan
- Reset: hold PRESET=0 for 3 edges with transfer=1 → PSEL=0, PENABLE=0, ready=0, rdata=0. FSM stays in IDLE until PRESET=1.
- FND write: transfer, write=1, addr=0x1000_1004, wdata=1234 with a registered-PREADY slave model in slot 1 →
  - PSEL=4'b0010, PADDR=0x1000_1004, PWDATA=1234.
  - PENABLE rises one cycle after PSEL.
  - ready high 3 edges after transfer, err=0.
  - Slave register 1 reads back 1234.
- Read: slot 2 returns PRDATA2=0xDEAD_BEEF with a zero-wait PREADY, addr=0x1000_2008 read → rdata=0xDEAD_BEEF for one cycle, 2 edges after transfer, err=0.
- Unmapped: addr=0x2000_0000 read → PSEL stays 0 throughout, ready after 2 edges, err=1, rdata=0. A second case at addr=0x1000_5000 gives the same result.
- Timeout: slot 3 with PREADY3 tied 0, TIMEOUT=16 → ready at edge 17 after transfer, err=1, rdata=0. A transfer pulse inserted during ACCESS is ignored: there is no second transaction.
- Reset mid-ACCESS: PRESET=0 for one edge during ACCESS → PSEL=0 and PENABLE=0 after that edge. No ready pulse. The next transfer after release completes normally.
